// File: rtl/vga_pkg.sv
// Shared QQVGA framebuffer constants, types and the checkerboard helper.
package vga_pkg;

    localparam int QQVGA_H_RES   = 160;
    localparam int QQVGA_V_RES   = 120;
    localparam int FB_ADDR_WIDTH = 15;

    typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } filler_state_t;

    // Checkerboard colour for one pixel, given the cell-select bits of x and y
    // and the frame polarity. Cell (0,0) is lit when the phase is 0.
    function automatic logic checker_pixel(input logic x_cell,
                                           input logic y_cell,
                                           input logic phase);
        return ~(x_cell ^ y_cell ^ phase);
    endfunction

endpackage

// File: rtl/filler_if.sv
// Framebuffer write port: write enable, linear address and pixel data.
interface filler_if #(
    parameter int ADDR_WIDTH = 15
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  pixel;

    modport master (
        output we,
        output write_addr,
        output pixel
    );

    modport slave (
        input we,
        input write_addr,
        input pixel
    );

endinterface

// File: rtl/fill_xy_counter.sv
// Raster position counters for the fill sweep: x, y and the linear address
// advance together so the address never needs a y*H_RES multiply.
module fill_xy_counter #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_WIDTH = 15,
    parameter int CELL_LOG2  = 3,
    parameter int X_WIDTH    = $clog2(H_RES),
    parameter int Y_WIDTH    = $clog2(V_RES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  x_cell,
    output logic                  y_cell,
    output logic                  frame_end
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_RES - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_RES - 1);

    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               line_end;

    // Detect the last pixel of a line and of a frame; the frame pulse only
    // fires on a cycle that actually advances the sweep.
    always_comb begin
        line_end  = (x == X_LAST);
        frame_end = en && line_end && (y == Y_LAST);
        x_cell    = x[CELL_LOG2];
        y_cell    = y[CELL_LOG2];
    end

    // Step x, wrap into the next line, and wrap the whole frame back to the
    // origin; the address follows with +1 per pixel and returns to 0 at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (en) begin
            if (line_end) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end

            if (frame_end) begin
                addr <= '0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/filler.sv
// Framebuffer fill engine: sweeps every QQVGA pixel continuously, writing an
// 8x8 checkerboard whose polarity flips after each complete frame.
module filler
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int H_RES      = QQVGA_H_RES,
    parameter int V_RES      = QQVGA_V_RES,
    parameter int CELL_LOG2  = 3
) (
    input  logic     clk_25,
    input  logic     reset_n,
    filler_if.master fb
);

    filler_state_t         state;
    filler_state_t         next_state;
    logic                  advance;
    logic                  phase;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  x_cell;
    logic                  y_cell;
    logic                  frame_end;

    // Next-state logic: reset (active high despite the name) forces IDLE,
    // otherwise the engine enters FILL and stays there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FILL;
            FILL:    next_state = FILL;
            default: next_state = IDLE;
        endcase
        if (reset_n) begin
            next_state = IDLE;
        end
        advance = (next_state == FILL);
    end

    // State register.
    always_ff @(posedge clk_25) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    fill_xy_counter #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CELL_LOG2 (CELL_LOG2)
    ) u_counter (
        .clk      (clk_25),
        .rst      (reset_n),
        .en       (advance),
        .addr     (cur_addr),
        .x_cell   (x_cell),
        .y_cell   (y_cell),
        .frame_end(frame_end)
    );

    // Frame polarity flips once the last pixel of a frame has been written.
    always_ff @(posedge clk_25) begin
        if (reset_n) begin
            phase <= 1'b0;
        end else if (frame_end) begin
            phase <= ~phase;
        end
    end

    // Registered write port: present the current pixel, so the first write
    // after reset release carries address 0 with no extra pipeline cycle.
    always_ff @(posedge clk_25) begin
        if (reset_n) begin
            fb.we         <= 1'b0;
            fb.write_addr <= '0;
            fb.pixel      <= 1'b0;
        end else begin
            fb.we         <= advance;
            fb.write_addr <= cur_addr;
            fb.pixel      <= checker_pixel(x_cell, y_cell, phase);
        end
    end

endmodule

// File: tb/tb_filler.sv
// Directed self-checking bench for the framebuffer fill engine.
module tb_filler;
    import vga_pkg::*;

    localparam int FRAME = QQVGA_H_RES * QQVGA_V_RES;

    logic clk;
    logic rst;

    int compareCount = 0;
    int failCount    = 0;

    filler_if #(.ADDR_WIDTH(FB_ADDR_WIDTH)) fb ();

    filler dut (
        .clk_25 (clk),
        .reset_n(rst),
        .fb     (fb.master)
    );

    // 25 MHz pixel clock.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Hand-computed checkpoints: cycle index after release, address, pixel.
    typedef struct {
        int     cyc;
        int     addr;
        logic   pix;
    } vector_t;

    vector_t vectors[$] = '{
        '{0,     0,     1'b1},
        '{7,     7,     1'b1},
        '{8,     8,     1'b0},
        '{15,    15,    1'b0},
        '{159,   159,   1'b0},
        '{160,   160,   1'b1},
        '{1280,  1280,  1'b0},
        '{1288,  1288,  1'b1},
        '{19199, 19199, 1'b0},
        '{19200, 0,     1'b0},
        '{19208, 8,     1'b1},
        '{38400, 0,     1'b1}
    };

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            if (failCount <= 20)
                $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive reset for a number of edges, leaving signals settled after the last.
    task automatic applyStimulus(input logic rstValue, input int cycles);
        rst = rstValue;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Independent pixel model from the cycle index using division/modulo.
    function automatic logic modelPixel(input int k);
        int a, x, y, ph;
        a  = k % FRAME;
        x  = a % QQVGA_H_RES;
        y  = a / QQVGA_H_RES;
        ph = (k / FRAME) % 2;
        return !(((x >> 3) & 1) ^ ((y >> 3) & 1) ^ ph);
    endfunction

    initial begin
        rst = 1'b1;
        $display("[TB] reset phase");
        applyStimulus(1'b1, 2);
        checkOutput("reset_we",   32'(fb.we),         0);
        checkOutput("reset_addr", 32'(fb.write_addr), 0);
        checkOutput("reset_pix",  32'(fb.pixel),      0);

        // Three full frames plus the start of a fourth, cycle by cycle.
        for (int k = 0; k < 3 * FRAME + 5001; k++) begin
            applyStimulus(1'b0, 1);
            checkOutput("sweep_we",   32'(fb.we),         1);
            checkOutput("sweep_addr", 32'(fb.write_addr), 32'(k % FRAME));
            checkOutput("sweep_pix",  32'(fb.pixel),      32'(modelPixel(k)));
            if (k < 3 * FRAME)
                checkOutput("addr_in_range", 32'(fb.write_addr < FRAME), 1);
            foreach (vectors[v]) begin
                if (vectors[v].cyc == k) begin
                    checkOutput("vec_addr", 32'(fb.write_addr), 32'(vectors[v].addr));
                    checkOutput("vec_pix",  32'(fb.pixel),      32'(vectors[v].pix));
                end
            end
        end

        // Now at address 5000 of an odd frame; reset for a single edge.
        checkOutput("pre_reset_addr", 32'(fb.write_addr), 5000);
        applyStimulus(1'b1, 1);
        checkOutput("mid_reset_we",   32'(fb.we),         0);
        checkOutput("mid_reset_addr", 32'(fb.write_addr), 0);
        checkOutput("mid_reset_pix",  32'(fb.pixel),      0);

        applyStimulus(1'b0, 1);
        checkOutput("restart_we",   32'(fb.we),         1);
        checkOutput("restart_addr", 32'(fb.write_addr), 0);
        checkOutput("restart_pix",  32'(fb.pixel),      1);
        applyStimulus(1'b0, 1);
        checkOutput("restart_addr1", 32'(fb.write_addr), 1);
        checkOutput("restart_pix1",  32'(fb.pixel),      1);
        applyStimulus(1'b0, 7);
        checkOutput("restart_addr8", 32'(fb.write_addr), 8);
        checkOutput("restart_pix8",  32'(fb.pixel),      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
